// File: rtl/j1_io_pkg.sv
// rtl/j1_io_pkg.sv - shared types and address helpers for the J1 I/O arbiter
package j1_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } io_arb_state_t;

  // Anything outside the bottom quarter of the address map is I/O space.
  function automatic logic io_space(input logic [15:0] addr);
    return addr[15:14] != 2'b00;
  endfunction

  // Extract the slot field; returned right-aligned in a 16-bit word.
  function automatic logic [15:0] slot_of(input logic [15:0] addr,
                                          input int lsb,
                                          input int bits);
    return (addr >> lsb) & 16'((1 << bits) - 1);
  endfunction

endpackage

// File: rtl/j1_io_slot_decoder.sv
// rtl/j1_io_slot_decoder.sv - address to one-hot slot select and read-data slice
module j1_io_slot_decoder
  import j1_io_pkg::*;
#(
  parameter int SLOT_BITS = 3,
  parameter int SLOT_LSB  = 4,
  localparam int N_SLOTS  = 2**SLOT_BITS
) (
  input  logic [15:0]           addr,
  input  logic [16*N_SLOTS-1:0] slot_rdata,
  output logic [N_SLOTS-1:0]    cs,
  output logic [15:0]           rdata
);

  logic [15:0] slot;

  assign slot = slot_of(addr, SLOT_LSB, SLOT_BITS);

  // One-hot decode of the slot field and matching 16-bit read slice.
  always_comb begin
    cs    = '0;
    rdata = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (slot[SLOT_BITS-1:0] == SLOT_BITS'(k)) begin
        cs[k] = 1'b1;
        rdata = slot_rdata[16*k +: 16];
      end
    end
  end

  logic unused_slot_hi;
  assign unused_slot_hi = ^slot;

endmodule

// File: rtl/j1_io_arbiter.sv
// rtl/j1_io_arbiter.sv - shares the J1 I/O port with a host master, CPU first
module j1_io_arbiter
  import j1_io_pkg::*;
#(
  parameter int SLOT_BITS = 3,
  parameter int SLOT_LSB  = 4,
  parameter int MAX_WAIT  = 255,
  localparam int N_SLOTS  = 2**SLOT_BITS
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_i,
  input  logic                   cpu_rd,
  input  logic                   cpu_wr,
  input  logic [15:0]            cpu_addr,
  input  logic [15:0]            cpu_dout,
  output logic [15:0]            cpu_din,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [15:0]            host_addr,
  input  logic [15:0]            host_wdata,
  output logic                   host_ack,
  output logic                   host_err,
  output logic [15:0]            host_rdata,
  output logic [N_SLOTS-1:0]     per_cs,
  output logic                   per_rd,
  output logic                   per_wr,
  output logic [15:0]            per_addr,
  output logic [15:0]            per_wdata,
  input  logic [16*N_SLOTS-1:0]  per_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  io_arb_state_t     state_q, state_d;
  logic              we_q, we_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic [15:0]       rdata_q, rdata_d;

  logic              cpu_io;
  logic              host_issue;
  logic [N_SLOTS-1:0] cpu_cs, host_cs;
  logic [15:0]       cpu_slice, host_slice;

  // cpu_rd is already I/O-qualified; cpu_wr also fires for RAM stores.
  assign cpu_io     = cpu_rd | (cpu_wr & io_space(cpu_addr));
  assign host_issue = (state_q == ISSUE) && !cpu_io;
  assign wait_inc   = wait_q + WAIT_W'(1);

  j1_io_slot_decoder #(.SLOT_BITS(SLOT_BITS), .SLOT_LSB(SLOT_LSB)) u_cpu_dec (
    .addr       (cpu_addr),
    .slot_rdata (per_rdata),
    .cs         (cpu_cs),
    .rdata      (cpu_slice)
  );

  j1_io_slot_decoder #(.SLOT_BITS(SLOT_BITS), .SLOT_LSB(SLOT_LSB)) u_host_dec (
    .addr       (addr_q),
    .slot_rdata (per_rdata),
    .cs         (host_cs),
    .rdata      (host_slice)
  );

  // State and host-transaction registers; reset drops any pending access.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: latch request, wait for a CPU-free cycle or time out, then ack.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (host_req) begin
          we_d    = host_we;
          addr_d  = host_addr;
          wdata_d = host_wdata;
          wait_d  = '0;
          err_d   = !io_space(host_addr);
          state_d = io_space(host_addr) ? ISSUE : ACK;
        end
      end
      ISSUE: begin
        if (!cpu_io) begin
          if (!we_q) rdata_d = host_slice;
          err_d   = 1'b0;
          state_d = ACK;
        end else begin
          // Timeout fires on the MAX_WAIT-th blocked cycle; ack follows.
          wait_d = wait_inc;
          if (wait_inc == WAIT_W'(MAX_WAIT)) begin
            err_d   = 1'b1;
            state_d = ACK;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Peripheral bus mux: CPU access first, then a pending host access, else idle.
  always_comb begin
    per_cs    = '0;
    per_rd    = 1'b0;
    per_wr    = 1'b0;
    per_addr  = '0;
    per_wdata = '0;
    if (cpu_io) begin
      per_cs    = cpu_cs;
      per_rd    = cpu_rd;
      per_wr    = cpu_wr & io_space(cpu_addr);
      per_addr  = cpu_addr;
      per_wdata = cpu_dout;
    end else if (host_issue) begin
      per_cs    = host_cs;
      per_rd    = !we_q;
      per_wr    = we_q;
      per_addr  = addr_q;
      per_wdata = wdata_q;
    end
  end

  assign cpu_din    = cpu_rd ? cpu_slice : '0;
  assign host_ack   = (state_q == ACK);
  assign host_err   = host_ack & err_q;
  assign host_rdata = rdata_q;

endmodule

// File: tb/tb_j1_io_arbiter.sv
// tb/tb_j1_io_arbiter.sv - directed self-checking bench for j1_io_arbiter
module tb_j1_io_arbiter;

  logic         sys_clk_i = 1'b0;
  logic         sys_rst_i;
  logic         cpu_rd, cpu_wr;
  logic [15:0]  cpu_addr, cpu_dout, cpu_din;
  logic         host_req, host_we, host_ack, host_err;
  logic [15:0]  host_addr, host_wdata, host_rdata;
  logic [7:0]   per_cs;
  logic         per_rd, per_wr;
  logic [15:0]  per_addr, per_wdata;
  logic [127:0] per_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk_i = ~sys_clk_i;

  j1_io_arbiter #(.SLOT_BITS(3), .SLOT_LSB(4), .MAX_WAIT(4)) dut (
    .sys_clk_i  (sys_clk_i),
    .sys_rst_i  (sys_rst_i),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_err   (host_err),
    .host_rdata (host_rdata),
    .per_cs     (per_cs),
    .per_rd     (per_rd),
    .per_wr     (per_wr),
    .per_addr   (per_addr),
    .per_wdata  (per_wdata),
    .per_rdata  (per_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge sys_clk_i);
    #1;
  endtask

  initial begin
    sys_rst_i  = 1'b1;
    cpu_rd     = 1'b0;
    cpu_wr     = 1'b0;
    cpu_addr   = '0;
    cpu_dout   = '0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    for (int k = 0; k < 8; k++) per_rdata[16*k +: 16] = 16'hA000 + 16'(k);
    per_rdata[16*1 +: 16] = 16'hBEEF;
    per_rdata[16*2 +: 16] = 16'h1234;

    next_cycle();
    next_cycle();
    check("rst_ack",   {31'd0, host_ack}, 32'd0);
    check("rst_err",   {31'd0, host_err}, 32'd0);
    check("rst_rdata", {16'd0, host_rdata}, 32'd0);
    check("rst_cs",    {24'd0, per_cs}, 32'd0);
    check("rst_strb",  {30'd0, per_rd, per_wr}, 32'd0);
    sys_rst_i = 1'b0;

    // CPU read, zero latency
    next_cycle();
    cpu_rd = 1'b1; cpu_addr = 16'h4010;
    #1;
    check("cpu_rd_cs",   {24'd0, per_cs}, 32'h02);
    check("cpu_rd_din",  {16'd0, cpu_din}, 32'hBEEF);
    check("cpu_rd_strb", {30'd0, per_rd, per_wr}, 32'd2);
    check("cpu_rd_addr", {16'd0, per_addr}, 32'h4010);

    // CPU RAM store ignored
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'h0100; cpu_dout = 16'h5555;
    #1;
    check("ram_st_wr", {31'd0, per_wr}, 32'd0);
    check("ram_st_cs", {24'd0, per_cs}, 32'd0);
    check("ram_st_din", {16'd0, cpu_din}, 32'd0);

    // CPU I/O write to slot 5
    cpu_addr = 16'h8050;
    #1;
    check("cpu_wr_wr", {31'd0, per_wr}, 32'd1);
    check("cpu_wr_cs", {24'd0, per_cs}, 32'h20);
    check("cpu_wr_wd", {16'd0, per_wdata}, 32'h5555);
    cpu_wr = 1'b0; cpu_addr = '0;

    // Host read 0x4020, bus free: ack in cycle 2
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h4020;
    next_cycle();  // cycle 1
    check("hrd_c1_ack", {31'd0, host_ack}, 32'd0);
    check("hrd_c1_rd",  {31'd0, per_rd}, 32'd1);
    check("hrd_c1_cs",  {24'd0, per_cs}, 32'h04);
    check("hrd_c1_adr", {16'd0, per_addr}, 32'h4020);
    next_cycle();  // cycle 2
    check("hrd_c2_ack", {31'd0, host_ack}, 32'd1);
    check("hrd_c2_err", {31'd0, host_err}, 32'd0);
    check("hrd_c2_dat", {16'd0, host_rdata}, 32'h1234);
    check("hrd_c2_rd",  {31'd0, per_rd}, 32'd0);
    host_req = 1'b0;
    next_cycle();
    check("hrd_c3_ack", {31'd0, host_ack}, 32'd0);
    check("hrd_c3_dat", {16'd0, host_rdata}, 32'h1234);

    // Host write 0x4030/0x00AA blocked by 3 CPU I/O cycles
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h4030; host_wdata = 16'h00AA;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      cpu_rd = 1'b1; cpu_addr = 16'h4010;
      #1;
      check("hwr_blk_rd",  {31'd0, per_rd}, 32'd1);
      check("hwr_blk_wr",  {31'd0, per_wr}, 32'd0);
      check("hwr_blk_din", {16'd0, cpu_din}, 32'hBEEF);
      check("hwr_blk_cs",  {24'd0, per_cs}, 32'h02);
      check("hwr_blk_ack", {31'd0, host_ack}, 32'd0);
    end
    next_cycle();  // cycle 4
    cpu_rd = 1'b0; cpu_addr = '0;
    #1;
    check("hwr_c4_wr",  {31'd0, per_wr}, 32'd1);
    check("hwr_c4_wd",  {16'd0, per_wdata}, 32'h00AA);
    check("hwr_c4_adr", {16'd0, per_addr}, 32'h4030);
    check("hwr_c4_cs",  {24'd0, per_cs}, 32'h08);
    check("hwr_c4_ack", {31'd0, host_ack}, 32'd0);
    next_cycle();  // cycle 5
    check("hwr_c5_ack", {31'd0, host_ack}, 32'd1);
    check("hwr_c5_err", {31'd0, host_err}, 32'd0);
    check("hwr_c5_dat", {16'd0, host_rdata}, 32'h1234);
    check("hwr_c5_wr",  {31'd0, per_wr}, 32'd0);
    host_req = 1'b0; host_we = 1'b0;
    next_cycle();

    // Host access to unmapped 0x0004: ack with error in cycle 1
    host_req = 1'b1; host_addr = 16'h0004;
    next_cycle();
    check("unm_ack",   {31'd0, host_ack}, 32'd1);
    check("unm_err",   {31'd0, host_err}, 32'd1);
    check("unm_strb",  {30'd0, per_rd, per_wr}, 32'd0);
    check("unm_cs",    {24'd0, per_cs}, 32'd0);
    check("unm_dat",   {16'd0, host_rdata}, 32'h1234);
    host_req = 1'b0;
    next_cycle();
    check("unm_c2_ack", {31'd0, host_ack}, 32'd0);

    // Timeout: continuous CPU I/O, MAX_WAIT=4
    host_req = 1'b1; host_addr = 16'h4070;
    cpu_rd = 1'b1; cpu_addr = 16'h4010;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      check("to_blk_ack", {31'd0, host_ack}, 32'd0);
      check("to_blk_cs",  {24'd0, per_cs}, 32'h02);
    end
    next_cycle();  // cycle 5
    check("to_ack", {31'd0, host_ack}, 32'd1);
    check("to_err", {31'd0, host_err}, 32'd1);
    check("to_dat", {16'd0, host_rdata}, 32'h1234);
    host_req = 1'b0;
    next_cycle();
    check("to_c6_ack", {31'd0, host_ack}, 32'd0);
    check("to_c6_err", {31'd0, host_err}, 32'd0);

    // Reset during ISSUE: dropped, no ack
    host_req = 1'b1; host_addr = 16'h4020;
    next_cycle();  // cycle 1, blocked by CPU
    check("rmt_ack", {31'd0, host_ack}, 32'd0);
    sys_rst_i = 1'b1;
    cpu_rd = 1'b0; cpu_addr = '0; host_req = 1'b0;
    #1;
    check("rmt_cs", {24'd0, per_cs}, 32'd0);
    check("rmt_rd", {31'd0, per_rd}, 32'd0);
    next_cycle();
    sys_rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      check("rmt_noack", {31'd0, host_ack}, 32'd0);
      check("rmt_nostb", {30'd0, per_rd, per_wr}, 32'd0);
    end
    check("rmt_dat", {16'd0, host_rdata}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
